seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits. It is the successor to the single-digit decoder: the digit count is parametrised, full hex 0-F is decoded, and a value is latched on a load strobe so the display never tears. The digit-enable lines are scanned with a programmable dwell time and an anti-ghosting blank interval. It sits between any counter or register block and the board's segment and digit pins.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
CLK_DIV, 12000, clock cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 16, cycles at the start of each slot during which all segments are off
DIG_ACTIVE_LOW, 1, 1 = digit_en asserted low; 0 = asserted high

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
value  input  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is rightmost
blank  input  DIGITS  per-digit force-off, sampled with value
load  input  1  one-cycle strobe that captures value and blank into the shadow registers
busy  output  1  high for the one cycle after load while the shadow registers update
segments  output  7 [0:6]  segment a..g, active-low (0 = lit)
digit_en  output  DIGITS  one-hot digit select; polarity set by DIG_ACTIVE_LOW

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; there are no asynchronous paths.
- Reset values:
  - prescaler = 0, digit index = 0.
  - shadow value = 0, shadow blank = all 1.
  - segments = 7'b1111111 (all off).
  - digit_en = all inactive.
  - busy = 0.
- Reset mid-slot: the next cycle has the reset state. No partial slot completes.
- Prescaler: counts 0..CLK_DIV-1. On CLK_DIV-1 it wraps to 0 and the digit index advances. Index DIGITS-1 wraps to 0.
- Slot phases:
  - Prescaler < BLANK_CYCLES (BLANK): segments all off and digit_en all inactive.
  - Otherwise (SHOW): digit_en asserts the current index only. segments = decode(shadow nibble[index]), or all off if shadow blank[index] = 1.
  - The output pins are registered, so the outputs lag the prescaler by 1 cycle.
- Decode table, active-high a..g before inversion:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg
  - 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg
  - C adef, d bcdeg, E adefg, F aefg
  - The output is the bitwise inverse of this pattern.
- load:
  - Shadow registers take value and blank at the clock edge where load = 1.
  - busy is high for the next cycle.
  - The new data is visible at the next SHOW cycle, mid-slot included.
  - A load coinciding with the slot-wrap edge uses the new data for the new digit.
  - load during rst is ignored.
  - Back-to-back loads: the last one wins.
- Without a load, the display holds the shadow contents forever.
- Scan period: DIGITS*CLK_DIV cycles. Duty per digit: (CLK_DIV-BLANK_CYCLES)/(DIGITS*CLK_DIV).

Optional Feature:
SEVEN_SEG_LZB_EN — leading-zero blanking.
- Defined: at load, the mask of leading-zero digits is computed. A digit is masked when its nibble is 0 and every higher-index nibble is 0. Digit 0 is never masked. The mask is ORed into shadow blank. The computation is registered in the same load cycle.
- Undefined: zeros are displayed as-is and the logic is absent.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry SEG_LUT constant (7-bit active-high patterns);
  - SEG_OFF = 7'b1111111;
  - the typedef seg_t (logic [0:6]);
  - the function hex_to_seg(nibble), returning the inverted pattern.
- Sub-module seven_seg_prescaler: the slot counter. It outputs slot_tick (pulse on wrap) and in_blank, and is reused by future LED/PWM scanners.
- Decode, shadow registers and digit index live in the top module.

Test Plan:
- Reset: DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2. Hold rst 3 cycles, then release -> segments=7'h7F, digit_en=4'b1111 during reset. The first SHOW is at cycle 3 after release with digit_en=4'b1110.
- Load 16'h12AF, blank=0 -> digits 0..3 show F (aefg → 0111000), A (0001000), 2 (0010010), 1 (1001111). The rotation period is 32 cycles, and each slot has 2 blank cycles with all pins off.
- Blank mask: load 16'h8888, blank=4'b0101 -> digits 0 and 2 show all off in SHOW. Digits 1 and 3 show 7'b0000000.
- Mid-slot load: load 16'h0000 at prescaler=5 -> busy=1 the next cycle. Segments change to "0" (0000001) at the next SHOW cycle of the same slot.
- Reset mid-scan: assert rst at digit index 2, prescaler 6 -> the next cycle has index 0, prescaler 0, shadow value 0, and all outputs off.
- SEVEN_SEG_LZB_EN: load 16'h0050 -> digits 3 and 2 are off, digit 1 shows 5 (0100100), digit 0 shows 0. Load 16'h0000 -> only digit 0 is lit, showing "0".

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment types, decode table and helpers for the display scanners.
package seven_seg_pkg;

  typedef logic [0:6] seg_t;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  // Active-high a..g patterns, a in the leftmost bit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return ~SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Slot counter for multiplexed scanners: pulses slot_tick on wrap and flags
// the leading blank interval of each slot.
module seven_seg_prescaler #(
  parameter int CLK_DIV      = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic slot_tick,
  output logic in_blank
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign slot_tick = (cnt == CW'(CLK_DIV - 1));
  assign in_blank  = (cnt < CW'(BLANK_CYCLES));

  always_ff @(posedge clk) begin
    if (rst)            cnt <= '0;
    else if (slot_tick) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with load-strobed shadow
// registers. Define SEVEN_SEG_LZB_EN to enable leading-zero blanking at load.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 12000,
  parameter int BLANK_CYCLES   = 16,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic                  busy,
  output logic [0:6]            segments,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] EN_OFF = {DIGITS{DIG_ACTIVE_LOW != 0}};

  logic [DIGITS-1:0][3:0] sh_val;
  logic [DIGITS-1:0]      sh_blank;
  logic [DIGITS-1:0]      lz_mask;
  logic [IW-1:0]          idx;
  logic                   slot_tick;
  logic                   in_blank;
  phase_t                 phase;
  seg_t                   seg_next;
  logic [DIGITS-1:0]      en_next;

  seven_seg_prescaler #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .slot_tick (slot_tick),
    .in_blank  (in_blank)
  );

`ifdef SEVEN_SEG_LZB_EN
  logic all_zero;

  // Walk down from the top digit; digit 0 always stays visible.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero & (value[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    phase    = in_blank ? PH_BLANK : PH_SHOW;
    seg_next = SEG_OFF;
    en_next  = EN_OFF;
    if (phase == PH_SHOW) begin
      en_next = (DIGITS'(1) << idx) ^ EN_OFF;
      if (!sh_blank[idx]) seg_next = hex_to_seg(sh_val[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val   <= '0;
      sh_blank <= '1;
      idx      <= '0;
      busy     <= 1'b0;
      segments <= SEG_OFF;
      digit_en <= EN_OFF;
    end else begin
      busy <= load;
      if (load) begin
        sh_val   <= value;
        sh_blank <= blank | lz_mask;
      end
      if (slot_tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      segments <= seg_next;
      digit_en <= en_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (DIGITS=4, CLK_DIV=8,
// BLANK_CYCLES=2); covers the SEVEN_SEG_LZB_EN build when that macro is set.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        load;
  logic        busy;
  logic [0:6]  segments;
  logic [3:0]  digit_en;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        last_load;
  logic [6:0]  exp_pat [4];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DIGITS         (4),
    .CLK_DIV        (8),
    .BLANK_CYCLES   (2),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .blank    (blank),
    .load     (load),
    .busy     (busy),
    .segments (segments),
    .digit_en (digit_en)
  );

  // Outputs after edge cyc reflect prescaler/index as they stood before it.
  function automatic logic [6:0] exp_seg();
    int q = cyc - 1;
    if ((q % 8) >= 2) return exp_pat[(q / 8) % 4];
    return 7'h7F;
  endfunction

  function automatic logic [3:0] exp_en();
    int q = cyc - 1;
    if ((q % 8) >= 2) return ~(4'b0001 << ((q / 8) % 4));
    return 4'hF;
  endfunction

  task automatic step();
    last_load = load;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_pat(input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
    exp_pat[3] = d3; exp_pat[2] = d2; exp_pat[1] = d1; exp_pat[0] = d0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b);
    value = v;
    blank = b;
    load  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; value = 16'hFFFF; blank = 4'h0;
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (segments !== 7'h7F || digit_en !== 4'hF || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold seg=%b/1111111 en=%b/1111 busy=%b/0", segments, digit_en, busy);
      end
    end
    load = 1'b0; rst = 1'b0; cyc = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en() || busy !== last_load) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d seg=%b/%b en=%b/%b busy=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en(), busy, last_load);
      end
    end
  endtask

  task automatic test_pattern();
    do_load(16'h12AF, 4'b0000);
    step();
    n_checks++;
    if (busy !== 1'b1 || segments !== exp_seg() || digit_en !== exp_en()) begin
      n_fail++;
      $display("FAIL pattern_load busy=%b/1 seg=%b/%b", busy, segments, exp_seg());
    end
    set_pat(7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en() || busy !== last_load) begin
        n_fail++;
        $display("FAIL pattern cyc=%0d seg=%b/%b en=%b/%b busy=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en(), busy, last_load);
      end
    end
  endtask

  task automatic test_blank_mask();
    do_load(16'h8888, 4'b0101);
    step();
    load = 1'b0;
    set_pat(7'b0000000, 7'h7F, 7'b0000000, 7'h7F);
    for (int i = 0; i < 34; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en() || busy !== last_load) begin
        n_fail++;
        $display("FAIL blank_mask cyc=%0d seg=%b/%b en=%b/%b busy=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en(), busy, last_load);
      end
    end
  endtask

  task automatic test_mid_slot();
    for (int i = 0; i < 8 && (cyc % 8) != 5; i++) step();
    do_load(16'h0000, 4'b0000);
    step();
    n_checks++;
    if (busy !== 1'b1 || segments !== exp_seg()) begin
      n_fail++;
      $display("FAIL mid_slot_busy busy=%b/1 seg=%b/%b", busy, segments, exp_seg());
    end
    load = 1'b0;
    set_pat(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
    step();
    n_checks++;
    if (segments !== 7'b0000001 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_slot_update seg=%b/0000001 busy=%b/0", segments, busy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en()) begin
        n_fail++;
        $display("FAIL mid_slot cyc=%0d seg=%b/%b en=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_load(16'h1111, 4'b0000);
    step();
    set_pat(7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111);
    do_load(16'h3333, 4'b0000);
    step();
    n_checks++;
    if (busy !== 1'b1 || segments !== exp_seg()) begin
      n_fail++;
      $display("FAIL b2b_first busy=%b/1 seg=%b/%b", busy, segments, exp_seg());
    end
    load = 1'b0;
    set_pat(7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110);
    for (int i = 0; i < 34; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en() || busy !== last_load) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d seg=%b/%b en=%b/%b busy=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en(), busy, last_load);
      end
    end
  endtask

  task automatic test_zeros();
    do_load(16'h0050, 4'b0000);
    step();
    load = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
    set_pat(7'h7F, 7'h7F, 7'b0100100, 7'b0000001);
`else
    set_pat(7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001);
`endif
    for (int i = 0; i < 33; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en()) begin
        n_fail++;
        $display("FAIL zeros_0050 cyc=%0d seg=%b/%b en=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en());
      end
    end
    do_load(16'h0000, 4'b0000);
    step();
    load = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'b0000001);
`else
    set_pat(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
`endif
    for (int i = 0; i < 33; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en()) begin
        n_fail++;
        $display("FAIL zeros_0000 cyc=%0d seg=%b/%b en=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 32 && (cyc % 32) != 22; i++) step();
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (segments !== 7'h7F || digit_en !== 4'hF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid seg=%b/1111111 en=%b/1111 busy=%b/0", segments, digit_en, busy);
    end
    rst = 1'b0; cyc = 0;
    set_pat(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (segments !== exp_seg() || digit_en !== exp_en() || busy !== last_load) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d seg=%b/%b en=%b/%b busy=%b/%b",
                 cyc, segments, exp_seg(), digit_en, exp_en(), busy, last_load);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_blank_mask();
    test_mid_slot();
    test_back_to_back();
    test_zeros();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
